result_writer: RTL and testbench

- Sits directly downstream of the allocator(s) inside the accelerator top level.
- Accepts convolution results, with output-grid coordinates, on a valid/ready interface and buffers them in a small FIFO.
- Optionally applies ReLU, computes output_memory_offset + y*out_dim + x, and writes each result through a stallable memory write port.
- Signals done once the configured number of results has been written, giving the scheduler a true end-of-pass condition.

---
 rtl/result_writer_pkg.sv | 26 ++
 rtl/result_fifo.sv | 58 +++++
 rtl/result_writer.sv | 178 +++++++++++++++++
 tb/tb_result_writer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_writer_pkg.sv
// result_writer_pkg: definitions shared by the result writer and its FIFO.
//   - default data / address widths
//   - FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   - FIFO entry field layout {data, x, y}, y in the low byte
package result_writer_pkg;

  localparam int DATA_W_DEF = 18;
  localparam int ADDR_W_DEF = 16;
  localparam int COORD_W    = 8;

  // Entry layout, LSB first: y, x, data
  localparam int Y_LSB    = 0;
  localparam int X_LSB    = Y_LSB + COORD_W;
  localparam int DATA_LSB = X_LSB + COORD_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int entry_w(input int data_w);
    return data_w + DATA_LSB;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// result_fifo: synchronous FIFO, power-of-two depth.
// Ports:
//   clk, rst        clock, async active-high reset (FIFO empty)
//   i_clear         synchronous flush (pointers to zero)
//   i_push/i_wdata  write request; ignored while full
//   i_pop           read request; ignored while empty
//   o_rdata         head entry (valid when !o_empty)
//   o_full/o_empty  status, derived only from registered pointers
module result_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: nothing is read until pushed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/result_writer.sv
// result_writer: buffers convolution results and writes them to memory.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start                    pulse; latches config, starts a pass (ignored in RUN)
//   out_dim, output_memory_offset, expected_count, relu_en   config, sampled on start
//   result_valid/ready       upstream handshake; result_data, result_x, result_y
//   write_addr/data/en       memory write request, held until write_ready
//   write_ready              memory accepts the write this cycle
//   done                     high while all expected results are written
//   error                    sticky: a result arrived outside RUN and was dropped
module result_writer
  import result_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        out_dim,
  input  logic [15:0]       output_memory_offset,
  input  logic [15:0]       expected_count,
  input  logic              relu_en,
  input  logic              result_valid,
  output logic              result_ready,
  input  logic [DATA_W-1:0] result_data,
  input  logic [7:0]        result_x,
  input  logic [7:0]        result_y,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              write_en,
  input  logic              write_ready,
  output logic              done,
  output logic              error
);

  localparam int ENTRY_W = entry_w(DATA_W);

  state_t            r_state;
  state_t            w_state_nxt;

  logic [7:0]        r_out_dim;
  logic [15:0]       r_offset;
  logic [15:0]       r_expected;
  logic              r_relu;
  logic [15:0]       r_wr_count;

  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_error;

  logic              w_run;
  logic              w_start_ok;
  logic              w_push;
  logic              w_pop;
  logic              w_hs;
  logic              w_last;
  logic [15:0]       w_cnt_inc;
  logic              w_full;
  logic              w_empty;
  logic [ENTRY_W-1:0] w_push_entry;
  logic [ENTRY_W-1:0] w_head;
  logic [7:0]        w_head_x;
  logic [7:0]        w_head_y;
  logic [DATA_W-1:0] w_head_data;
  logic [15:0]       w_prod;
  logic [15:0]       w_sum;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  assign w_run        = (r_state == ST_RUN);
  assign w_start_ok   = start && !w_run;
  assign result_ready = w_run && !w_full;
  assign w_push       = result_valid && result_ready;
  assign w_hs         = r_wr_en && write_ready;
  assign w_cnt_inc    = r_wr_count + 16'd1;
  assign w_last       = w_hs && (w_cnt_inc == r_expected);
  // Reload the stage when it is empty or draining this cycle. Never reload on
  // the final handshake: surplus entries must not produce a write in DONE.
  assign w_pop        = w_run && !w_empty && (!r_wr_en || w_hs) && !w_last;

  assign w_push_entry = {result_data, result_x, result_y};

  result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_start_ok),
    .i_push  (w_push),
    .i_wdata (w_push_entry),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_y    = w_head[Y_LSB +: COORD_W];
  assign w_head_x    = w_head[X_LSB +: COORD_W];
  assign w_head_data = w_head[DATA_LSB +: DATA_W];

  // 8x8 unsigned product fits 16 bits; the sum wraps modulo 2^16 by design.
  assign w_prod = {8'd0, w_head_y} * {8'd0, r_out_dim};
  assign w_sum  = r_offset + w_prod + {8'd0, w_head_x};
  assign w_addr = ADDR_W'(w_sum);
  assign w_data = (r_relu && w_head_data[DATA_W-1]) ? '0 : w_head_data;

  // FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) w_state_nxt = (expected_count == 16'd0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (w_last) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Configuration and written count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_dim  <= '0;
      r_offset   <= '0;
      r_expected <= '0;
      r_relu     <= 1'b0;
      r_wr_count <= '0;
    end else if (w_start_ok) begin
      r_out_dim  <= out_dim;
      r_offset   <= output_memory_offset;
      r_expected <= expected_count;
      r_relu     <= relu_en;
      r_wr_count <= '0;
    end else if (w_hs && w_run) begin
      r_wr_count <= w_cnt_inc;
    end
  end

  // One-entry output stage; address/data held until the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_start_ok) begin
      r_wr_en <= 1'b0;
    end else if (w_pop) begin
      r_wr_en   <= 1'b1;
      r_wr_addr <= w_addr;
      r_wr_data <= w_data;
    end else if (w_hs) begin
      r_wr_en <= 1'b0;
    end
  end

  // Sticky drop flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_error <= 1'b0;
    else if (result_valid && !w_run) r_error <= 1'b1;
  end

  assign write_en   = r_wr_en;
  assign write_addr = r_wr_addr;
  assign write_data = r_wr_data;
  assign done       = (r_state == ST_DONE);
  assign error      = r_error;

endmodule

// File: tb/tb_result_writer.sv
module tb_result_writer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  out_dim;
  logic [15:0] output_memory_offset;
  logic [15:0] expected_count;
  logic        relu_en;
  logic        result_valid;
  logic        result_ready;
  logic [17:0] result_data;
  logic [7:0]  result_x;
  logic [7:0]  result_y;
  logic [15:0] write_addr;
  logic [17:0] write_data;
  logic        write_en;
  logic        write_ready;
  logic        done;
  logic        error;

  result_writer #(.FIFO_DEPTH(8), .DATA_W(18), .ADDR_W(16)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .out_dim              (out_dim),
    .output_memory_offset (output_memory_offset),
    .expected_count       (expected_count),
    .relu_en              (relu_en),
    .result_valid         (result_valid),
    .result_ready         (result_ready),
    .result_data          (result_data),
    .result_x             (result_x),
    .result_y             (result_y),
    .write_addr           (write_addr),
    .write_data           (write_data),
    .write_en             (write_en),
    .write_ready          (write_ready),
    .done                 (done),
    .error                (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt = 0;
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];

  // Record every write handshake in order.
  always @(posedge clk) begin
    if (write_en && write_ready) begin
      q_addr.push_back(32'(write_addr));
      q_data.push_back(32'(write_data));
      hs_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] dim, input logic [15:0] off,
                          input logic [15:0] exp_n, input logic relu);
    out_dim = dim;
    output_memory_offset = off;
    expected_count = exp_n;
    relu_en = relu;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [7:0] x, input logic [7:0] y, input logic [17:0] d);
    int n;
    n = 0;
    result_x = x;
    result_y = y;
    result_data = d;
    result_valid = 1'b1;
    while (!result_ready && n < 50) begin
      tick();
      n++;
    end
    if (!result_ready) chk("push_timeout", 32'd0, 32'd1);
    else tick();
    result_valid = 1'b0;
  endtask

  task automatic wait_hs(input int target, input string tag);
    int n;
    n = 0;
    while (hs_cnt < target && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_hs"}, 32'(hs_cnt), 32'(target));
  endtask

  task automatic exp_wr(input string tag, input logic [31:0] a, input logic [31:0] d);
    if (q_addr.size() == 0) begin
      chk({tag, "_missing"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_addr"}, q_addr.pop_front(), a);
      chk({tag, "_data"}, q_data.pop_front(), d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int acc;
    logic [15:0] snap_a;
    logic [17:0] snap_d;

    rst = 1'b1;
    start = 1'b0;
    out_dim = '0;
    output_memory_offset = '0;
    expected_count = '0;
    relu_en = 1'b0;
    result_valid = 1'b0;
    result_data = '0;
    result_x = '0;
    result_y = '0;
    write_ready = 1'b0;
    #12;
    chk("rst_ready", 32'(result_ready), 0);
    chk("rst_wen",   32'(write_en), 0);
    chk("rst_waddr", 32'(write_addr), 0);
    chk("rst_wdata", 32'(write_data), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_error", 32'(error), 0);
    rst = 1'b0;
    tick();

    // Basic pass
    write_ready = 1'b1;
    base = hs_cnt;
    do_start(8'd4, 16'h0100, 16'd3, 1'b0);
    chk("b_done0", 32'(done), 0);
    chk("b_ready", 32'(result_ready), 1);
    push(8'd1, 8'd0, 18'd5);
    push(8'd2, 8'd1, 18'h3FFFD);
    push(8'd3, 8'd3, 18'd7);
    wait_hs(base + 2, "b2");
    chk("b_done_early", 32'(done), 0);
    wait_hs(base + 3, "b3");
    chk("b_done", 32'(done), 1);
    exp_wr("b_w0", 32'h0101, 32'd5);
    exp_wr("b_w1", 32'h0106, 32'h3FFFD);
    exp_wr("b_w2", 32'h010F, 32'd7);
    chk("b_error", 32'(error), 0);

    // ReLU
    base = hs_cnt;
    do_start(8'd4, 16'h0200, 16'd2, 1'b1);
    chk("r_done0", 32'(done), 0);
    push(8'd0, 8'd0, 18'h3FFFF);
    push(8'd1, 8'd0, 18'd9);
    wait_hs(base + 2, "r");
    exp_wr("r_w0", 32'h0200, 32'd0);
    exp_wr("r_w1", 32'h0201, 32'd9);
    chk("r_done", 32'(done), 1);

    // Backpressure
    write_ready = 1'b0;
    do_start(8'd16, 16'h0000, 16'd10, 1'b0);
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      if (!result_ready) break;
      result_x = 8'(i);
      result_y = 8'd0;
      result_data = 18'(100 + i);
      result_valid = 1'b1;
      tick();
      acc++;
    end
    result_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 9);
    chk("bp_wen", 32'(write_en), 1);
    chk("bp_addr", 32'(write_addr), 0);
    chk("bp_data", 32'(write_data), 100);
    snap_a = write_addr;
    snap_d = write_data;
    repeat (3) tick();
    chk("bp_hold_en", 32'(write_en), 1);
    chk("bp_hold_addr", 32'(write_addr), 32'(snap_a));
    chk("bp_hold_data", 32'(write_data), 32'(snap_d));
    write_ready = 1'b1;
    base = hs_cnt;
    repeat (9) tick();
    chk("bp_rate", 32'(hs_cnt - base), 9);
    for (int i = 0; i < 9; i++) exp_wr("bp_w", 32'(i), 32'(100 + i));
    chk("bp_done_early", 32'(done), 0);
    push(8'd9, 8'd0, 18'd109);
    wait_hs(base + 10, "bp10");
    exp_wr("bp_w9", 32'd9, 32'd109);
    chk("bp_done", 32'(done), 1);

    // Boundaries
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
    chk("z_done_pre", 32'(done), 0);
    do_start(8'd4, 16'h0000, 16'd0, 1'b0);
    chk("z_done", 32'(done), 1);
    base = hs_cnt;
    do_start(8'd4, 16'hFFFF, 16'd1, 1'b0);
    chk("wrap_done0", 32'(done), 0);
    push(8'd1, 8'd0, 18'd3);
    wait_hs(base + 1, "wrap");
    exp_wr("wrap_w", 32'h0000, 32'd3);
    chk("wrap_done", 32'(done), 1);
    chk("wrap_error", 32'(error), 0);
    base = hs_cnt;
    result_x = 8'd5;
    result_data = 18'd11;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    repeat (3) tick();
    chk("drop_error", 32'(error), 1);
    chk("drop_nowrite", 32'(hs_cnt - base), 0);
    chk("drop_wen", 32'(write_en), 0);

    // Reset mid-pass
    write_ready = 1'b0;
    do_start(8'd4, 16'h0400, 16'd5, 1'b0);
    push(8'd0, 8'd0, 18'd1);
    push(8'd1, 8'd0, 18'd2);
    push(8'd2, 8'd0, 18'd3);
    push(8'd3, 8'd0, 18'd4);
    chk("mr_wen_pre", 32'(write_en), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_wen", 32'(write_en), 0);
    chk("mr_done", 32'(done), 0);
    chk("mr_ready", 32'(result_ready), 0);
    chk("mr_error", 32'(error), 0);
    #10;
    rst = 1'b0;
    write_ready = 1'b1;
    base = hs_cnt;
    repeat (5) tick();
    chk("mr_nostale", 32'(hs_cnt - base), 0);
    chk("mr_wen_post", 32'(write_en), 0);

    // Start ignored in RUN
    base = hs_cnt;
    do_start(8'd4, 16'h0300, 16'd4, 1'b0);
    push(8'd0, 8'd0, 18'd1);
    push(8'd1, 8'd0, 18'd2);
    wait_hs(base + 2, "ig2");
    do_start(8'd8, 16'h0500, 16'd1, 1'b1);
    chk("ig_done_mid", 32'(done), 0);
    push(8'd2, 8'd1, 18'h3FFFF);
    push(8'd3, 8'd1, 18'd5);
    wait_hs(base + 4, "ig4");
    chk("ig_done", 32'(done), 1);
    exp_wr("ig_w0", 32'h0300, 32'd1);
    exp_wr("ig_w1", 32'h0301, 32'd2);
    exp_wr("ig_w2", 32'h0306, 32'h3FFFF);
    exp_wr("ig_w3", 32'h0307, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
